// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the sequential chunked adder.
package seq_adder_pkg;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Default geometry of the datapath adder
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CHUNK = 8;
    localparam int unsigned NCHUNK    = DEF_WIDTH / DEF_CHUNK;

    // Ceiling log2; returns 0 for v <= 1
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

    // Width of a counter over n values, at least one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (clog2(n) == 0) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple-carry slice built from full-adder cells.
module rca_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    // One full-adder cell per bit
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co       = c[CHUNK];
    assign c_msb_in = c[CHUNK - 1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: one CHUNK-wide ripple slice reused per cycle,
// carry registered between chunks, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SEQ_ADDER_OVF_EN.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             busy,
    output logic             done
`ifdef SEQ_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NCH   = WIDTH / CHUNK;
    localparam int unsigned IDX_W = idx_width(NCH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry;
    logic [IDX_W-1:0]   idx;

    logic [CHUNK-1:0]   x_c;
    logic [CHUNK-1:0]   y_c;
    logic [CHUNK-1:0]   sum_c;
    logic               co_c;
    logic               c_msb_c;

    // Select the operand chunk addressed by idx
    always_comb begin
        x_c = '0;
        y_c = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (idx == IDX_W'(k)) begin
                x_c = a_r[k*CHUNK +: CHUNK];
                y_c = b_r[k*CHUNK +: CHUNK];
            end
        end
    end

    rca_chunk #(
        .CHUNK (CHUNK)
    ) u_slice (
        .x        (x_c),
        .y        (y_c),
        .ci       (carry),
        .sum      (sum_c),
        .co       (co_c),
        .c_msb_in (c_msb_c)
    );

`ifndef SEQ_ADDER_OVF_EN
    logic c_msb_unused;
    assign c_msb_unused = c_msb_c;
`endif

    // Controller, operand/carry/index registers and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            s     <= '0;
            c_out <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    // Leaving DONE publishes the result held since the last chunk
                    if (state == S_DONE) begin
                        done <= 1'b1;
                    end
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b ^ {WIDTH{sub}};
                        carry <= sub ? 1'b1 : c_in;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < int'(NCH); k++) begin
                        if (idx == IDX_W'(k)) begin
                            s[k*CHUNK +: CHUNK] <= sum_c;
                        end
                    end
                    carry <= co_c;
                    idx   <= idx + IDX_W'(1);
                    if (idx == LAST) begin
                        c_out <= co_c;
`ifdef SEQ_ADDER_OVF_EN
                        ovf   <= c_msb_c ^ co_c;
`endif
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
